// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte sender with open-drain line control; define PS2_TX_RETRY_EN to retry NACK/timeout up to twice
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 7425,
  parameter int TIMEOUT_CYCLES = 148500
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] byte_in,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe_out,
  output logic       ps2_data_oe_out,
  output logic       done_out,
  output logic       error_out
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE} state_t;
  state_t state;
  logic [2:0] clk_s;
  logic [1:0] dat_s;
  logic [8:0] frame;
  logic [9:0] sh;
  logic [3:0] bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic fall, tmo_hit, fail;
`ifdef PS2_TX_RETRY_EN
  logic [1:0] tries;
`endif
  // clk_s[1] is the synchronised clock, clk_s[2] its previous value
  assign fall = clk_s[2] & ~clk_s[1];
  assign tmo_hit = (state == SHIFT || state == ACK || state == WAIT_IDLE) && tmo_cnt == TMO_LAST;
  assign fail = tmo_hit || (state == ACK && fall && dat_s[1]);
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      clk_s <= '1;
      dat_s <= '1;
      frame <= '0;
      sh <= '1;
      bit_cnt <= '0;
      inh_cnt <= '0;
      tmo_cnt <= '0;
      ready_out <= 1'b1;
      ps2_clk_oe_out <= 1'b0;
      ps2_data_oe_out <= 1'b0;
      done_out <= 1'b0;
      error_out <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      tries <= '0;
`endif
    end else begin
      clk_s <= {clk_s[1:0], ps2_clk_in};
      dat_s <= {dat_s[0], ps2_data_in};
      done_out <= 1'b0;
      error_out <= 1'b0;
      tmo_cnt <= tmo_cnt + 1'b1;
      if (fail) begin
        ps2_clk_oe_out <= 1'b0;
        ps2_data_oe_out <= 1'b0;
        error_out <= 1'b1;
        state <= IDLE;
`ifdef PS2_TX_RETRY_EN
        if (tries != 2'd2) begin
          tries <= tries + 1'b1;
          ps2_clk_oe_out <= 1'b1;
          error_out <= 1'b0;
          inh_cnt <= '0;
          state <= INHIBIT;
        end
`endif
      end else begin
        case (state)
          IDLE: begin
            if (valid_in && ready_out) begin
              frame <= {~^byte_in, byte_in};
              ready_out <= 1'b0;
              ps2_clk_oe_out <= 1'b1;
              inh_cnt <= '0;
              state <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
              tries <= '0;
`endif
            end else ready_out <= 1'b1;
          end
          INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
              ps2_clk_oe_out <= 1'b0;
              ps2_data_oe_out <= 1'b1;
              sh <= {1'b1, frame};
              tmo_cnt <= '0;
              state <= RTS;
            end else inh_cnt <= inh_cnt + 1'b1;
          end
          RTS: begin
            bit_cnt <= '0;
            state <= SHIFT;
          end
          // edges 1..9 shift out data then parity; edge 10 shifts out the stop bit (release)
          SHIFT: begin
            if (fall) begin
              ps2_data_oe_out <= ~sh[0];
              sh <= {1'b1, sh[9:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd9) state <= ACK;
            end
          end
          ACK: if (fall) state <= WAIT_IDLE;
          WAIT_IDLE: begin
            if (clk_s[1] && dat_s[1]) begin
              done_out <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized bench for ps2_host_tx with a behavioural PS/2 device model; honours PS2_TX_RETRY_EN
`timescale 1ns/1ps
module tb_ps2_host_tx;
`ifdef PS2_TX_RETRY_EN
  localparam int NTRY = 3;
`else
  localparam int NTRY = 1;
`endif
  logic clk_in = 1'b0;
  logic rst_in;
  logic [7:0] byte_in;
  logic valid_in;
  logic ready_out, ps2_clk_oe_out, ps2_data_oe_out, done_out, error_out;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic ps2_clk, ps2_data;
  int n_checks = 0, n_errors = 0;
  int h = 10;
  int cyc = 0, inh_run = 0, last_inh = 0, inh_seqs = 0, rel_cyc = 0, err_cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  assign ps2_clk = ~(ps2_clk_oe_out | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe_out | dev_data_low);
  always #5 clk_in = ~clk_in;
  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .valid_in(valid_in),
    .ready_out(ready_out), .ps2_clk_in(ps2_clk), .ps2_data_in(ps2_data),
    .ps2_clk_oe_out(ps2_clk_oe_out), .ps2_data_oe_out(ps2_data_oe_out),
    .done_out(done_out), .error_out(error_out)
  );
  always @(negedge clk_in) begin
    cyc++;
    if (ps2_clk_oe_out === 1'b1) inh_run++;
    else if (inh_run != 0) begin
      last_inh = inh_run;
      inh_seqs++;
      rel_cyc = cyc;
      inh_run = 0;
    end
    if (done_out === 1'b1) done_cnt++;
    if (error_out === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (done_out === 1'b1 && error_out === 1'b1) both_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // frame as seen by the device: {stop, odd parity, data, start}
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b, 1'b0};
  endfunction
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk_in);
    while (!ready_out && n < 5000) begin
      @(negedge clk_in);
      n++;
    end
    chk("send_ready", 32'(ready_out), 1);
    byte_in = b;
    valid_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0;
  endtask
  task automatic device_xfer(input bit ack, input int stop_after, output logic [10:0] got);
    int n = 0;
    got = '0;
    while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    chk("dev_rts", 32'(n < 3000), 1);
    if (n >= 3000) return;
    repeat (h) @(negedge clk_in);
    got[0] = ps2_data;
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      repeat (h) @(negedge clk_in);
      dev_clk_low = 1'b0;
      if (i <= 10) got[i] = ps2_data;
      if (i == 10 && ack) dev_data_low = 1'b1;
      if (i == stop_after) return;
      repeat (h) @(negedge clk_in);
    end
    dev_data_low = 1'b0;
  endtask
  task automatic wait_end(input int d0, input int e0, input int limit);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < limit) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    chk("end_seen", 32'(done_cnt != d0 || err_cnt != e0), 1);
  endtask
  task automatic run_ok(input logic [7:0] b, input string tag);
    logic [10:0] got;
    int d0 = done_cnt, e0 = err_cnt;
    send(b);
    device_xfer(1'b1, 0, got);
    chk({tag, "_frame"}, 32'(got), 32'(frame_of(b)));
    chk({tag, "_inhibit"}, last_inh, 20);
    wait_end(d0, e0, 500);
    @(negedge clk_in);
    chk({tag, "_ready"}, 32'(ready_out), 1);
    repeat (5) @(negedge clk_in);
    #1;
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_no_err"}, err_cnt - e0, 0);
  endtask
  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [10:0] got;
    logic [7:0] rb;
    int d0, e0, i0;
    rst_in = 1'b0;
    valid_in = 1'b0;
    byte_in = '0;
    repeat (3) @(negedge clk_in);
    chk("rst_ready", 32'(ready_out), 1);
    chk("rst_clk_oe", 32'(ps2_clk_oe_out), 0);
    chk("rst_data_oe", 32'(ps2_data_oe_out), 0);
    chk("rst_done", 32'(done_out), 0);
    chk("rst_error", 32'(error_out), 0);
    rst_in = 1'b1;
    run_ok(8'hED, "ed");
    run_ok(8'hF4, "f4");
    run_ok(8'h00, "zero");
    for (int k = 0; k < 6; k++) begin
      h = int'($urandom_range(6, 16));
      run_ok(8'($urandom), "rnd");
    end
    h = 10;
    // device never acknowledges
    d0 = done_cnt; e0 = err_cnt; i0 = inh_seqs;
    send(8'hA5);
    for (int r = 0; r < NTRY; r++) device_xfer(1'b0, 0, got);
    wait_end(d0, e0, 500);
    repeat (5) @(negedge clk_in);
    #1;
    chk("nack_err", err_cnt - e0, 1);
    chk("nack_no_done", done_cnt - d0, 0);
    chk("nack_inhibits", inh_seqs - i0, NTRY);
    // device stalls after the fourth falling edge
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C);
    for (int r = 0; r < NTRY; r++) device_xfer(1'b1, 4, got);
    wait_end(d0, e0, 3000);
    @(negedge clk_in);
    #1;
    chk("tmo_err", err_cnt - e0, 1);
    chk("tmo_no_done", done_cnt - d0, 0);
    chk("tmo_gap", err_cyc - rel_cyc, 2000);
    chk("tmo_clk_oe", 32'(ps2_clk_oe_out), 0);
    chk("tmo_data_oe", 32'(ps2_data_oe_out), 0);
    // asynchronous reset in the middle of the shift phase
    rb = 8'hED;
    d0 = done_cnt; e0 = err_cnt;
    send(rb);
    device_xfer(1'b1, 5, got);
    chk("mid_data_oe", 32'(ps2_data_oe_out), 32'(!rb[4]));
    #2 rst_in = 1'b0;
    #1;
    chk("arst_clk_oe", 32'(ps2_clk_oe_out), 0);
    chk("arst_data_oe", 32'(ps2_data_oe_out), 0);
    chk("arst_ready", 32'(ready_out), 1);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (10) @(negedge clk_in);
    #1;
    chk("arst_no_done", done_cnt - d0, 0);
    chk("arst_no_err", err_cnt - e0, 0);
    run_ok(8'hED, "post_rst");
    // request held during a busy transfer is taken only when ready returns
    d0 = done_cnt; e0 = err_cnt; i0 = inh_seqs;
    send(8'hED);
    byte_in = 8'h55;
    valid_in = 1'b1;
    device_xfer(1'b1, 0, got);
    chk("hold_first", 32'(got), 32'(frame_of(8'hED)));
    wait_end(d0, e0, 500);
    @(negedge clk_in);
    chk("hold_ready", 32'(ready_out), 1);
    @(negedge clk_in);
    chk("hold_accept", 32'(ready_out), 0);
    valid_in = 1'b0;
    device_xfer(1'b1, 0, got);
    chk("hold_second", 32'(got), 32'(frame_of(8'h55)));
    wait_end(d0 + 1, e0, 500);
    repeat (3) @(negedge clk_in);
    #1;
    chk("hold_dones", done_cnt - d0, 2);
    chk("hold_inhibits", inh_seqs - i0, 2);
    chk("no_overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 7425, clock-low inhibit length (100 us at 74.25 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 148500, maximum cycles from clock release to ACK (2 ms at 74.25 MHz).
REQ-003 SHALL have port clk_in, input, 1 bit, the single system clock (pixel clock domain).
REQ-004 SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port byte_in, input, 8 bits: command byte to send to the keyboard, such as 0xED (set LEDs).
REQ-006 SHALL have port valid_in, input, 1 bit: request; byte_in is captured when valid_in and ready_out are both high.
REQ-007 SHALL have port ready_out, output, 1 bit: high only in IDLE.
REQ-008 SHALL have port ps2_clk_in, input, 1 bit: raw PS/2 clock line level (asynchronous).
REQ-009 SHALL have port ps2_data_in, input, 1 bit: raw PS/2 data line level (asynchronous).
REQ-010 SHALL have port ps2_clk_oe_out, output, 1 bit: 1 means pull the clock line low, 0 means release it (open-drain).
REQ-011 SHALL have port ps2_data_oe_out, output, 1 bit: 1 means pull the data line low, 0 means release it.
REQ-012 SHALL have port done_out, output, 1 bit: one-cycle pulse when the transfer completes with ACK.
REQ-013 SHALL have port error_out, output, 1 bit: one-cycle pulse on NACK or timeout.

Function
REQ-014 SHALL synchronise ps2_clk_in and ps2_data_in through two flip-flops each, and SHALL detect clock falling edges on the synchronised value.
REQ-015 SHALL implement the states IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
- IDLE: outputs are released.
- A handshake in IDLE latches byte_in, computes odd parity (the XOR of the bits, inverted) and moves to INHIBIT.
REQ-016 INHIBIT SHALL assert ps2_clk_oe_out for exactly INHIBIT_CYCLES cycles, then move to RTS.
REQ-017 RTS SHALL assert ps2_data_oe_out (start bit 0), deassert ps2_clk_oe_out on the same cycle, start the timeout counter and enter SHIFT.
REQ-018 SHIFT SHALL count synchronised falling edges n = 1..10:
- edges 1-8: drive data bit n-1, LSB first (oe = ~bit);
- edge 9: drive the parity bit;
- edge 10: release data (stop bit), then enter ACK.
REQ-019 The data line update SHALL occur no later than 1 cycle after the synchronised falling edge is detected.
REQ-020 ACK SHALL sample synchronised data on falling edge 11:
- low means ACK; go to WAIT_IDLE;
- high means NACK; pulse error_out and return to IDLE.
REQ-021 WAIT_IDLE SHALL wait until both synchronised lines are high, then pulse done_out and return to IDLE.
REQ-022 If the timeout counter reaches TIMEOUT_CYCLES in SHIFT, ACK or WAIT_IDLE, the block SHALL release both lines, pulse error_out and return to IDLE.
REQ-023 valid_in while ready_out is low SHALL be ignored; the request is not queued.
REQ-024 ready_out SHALL go high on the cycle after done_out or error_out; a new request in that cycle is accepted normally.
REQ-025 done_out and error_out SHALL never be high in the same cycle.

Reset
REQ-026 Asserting rst_in low SHALL immediately, without waiting for a clock edge:
- force IDLE;
- set ready_out=1, both oe outputs=0, done_out=0 and error_out=0;
- clear the counters and synchronisers (synchroniser outputs to 1).
REQ-027 Reset during any state, including mid-SHIFT, SHALL release both lines with no done_out or error_out pulse.

Configuration
REQ-028 With macro PS2_TX_RETRY_EN defined, NACK or timeout SHALL restart the transfer from INHIBIT with the same byte, up to 2 retries.
- error_out pulses only after the third failure.
- ready_out stays low throughout the retries.
REQ-029 With PS2_TX_RETRY_EN undefined, the first NACK or timeout SHALL pulse error_out and return to IDLE, with no retry logic synthesised.

Verification (INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000 in the bench)
REQ-030 Send 0xED with a device model that ACKs: the bench SHALL check:
- clock held low 20 cycles;
- data bits sampled on device rising edges = 1,0,1,1,0,1,1,1;
- parity=1, stop=1;
- done_out pulses once, then ready_out=1.
REQ-031 Send 0xF4 and 0x00: the bench SHALL check parity bits 0 and 1 respectively, each followed by done_out.
REQ-032 Device model leaves data high on edge 11: error_out SHALL pulse once and no done_out SHALL occur; with PS2_TX_RETRY_EN, three full inhibit sequences SHALL precede error_out.
REQ-033 Device stops clocking after edge 4: error_out SHALL pulse 2000 cycles after clock release and both oe outputs SHALL be 0 afterwards.
REQ-034 Assert rst_in low after edge 5: the bench SHALL check, on the same cycle:
- both oe outputs=0 and ready_out=1;
- no done_out or error_out pulse;
- a subsequent 0xED transfer completes correctly.
REQ-035 Hold valid_in high with byte 0x55 during a 0xED transfer: only 0xED SHALL be sent, and 0x55 SHALL be accepted the cycle ready_out returns high.
